exe_stage: RTL
==============

# exe_stage

Execute stage of the five-stage LoongArch32 pipeline. It sits between the decode stage and the memory stage. It latches the decode bus, runs the ALU, and issues the data-SRAM request for loads and stores. It also returns destination, load flag and result to decode, which uses them for hazard detection and forwarding.

## Interface

Parameters (as `define in mycpu_head.v):
- DS_TO_ES_BUS_WD, 157, width of the decode→execute bus.
- ES_TO_MS_BUS_WD, 74, width of the execute→memory bus.

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ms_allowin  in  1  memory stage can accept.
- es_allowin  out  1  execute can accept.
- ds_to_es_valid  in  1  decode presents a valid instruction.
- ds_to_es_bus  in  157  fields, MSB→LSB:
  - alu_op[12], load_op, ld_type[3], src1_is_pc, src2_is_imm, gr_we, st_type[2], mem_we, dest[5]
  - imm[32], rj_value[32], rkd_value[32], pc[32]
  - res_from_mem, inst_no_dest
- es_to_ms_valid  out  1  valid instruction to the memory stage.
- es_to_ms_bus  out  74  fields, MSB→LSB: res_from_mem, ld_type[3], gr_we, dest[5], alu_result[32], pc[32].
- es_to_ds_dest  out  5  live destination register, or 0 when there is none.
- es_to_ds_load_op  out  1  the instruction in execute is a load.
- es_to_ds_result  out  32  ALU result, used for forwarding.
- data_sram_en  out  1  data SRAM access enable.
- data_sram_we  out  4  byte write strobes.
- data_sram_addr  out  32  byte address.
- data_sram_wdata  out  32  write data.
- debug_ex_pc  out  32  pc of the instruction in execute.

## Operation

Pipeline handshake:
- es_ready_go = 1.
- es_allowin = !es_valid | (es_ready_go & ms_allowin).
- es_to_ms_valid = es_valid & es_ready_go.
- When es_allowin is high, es_valid ← ds_to_es_valid.
- When ds_to_es_valid & es_allowin, bus_r ← ds_to_es_bus.

ALU operands:
- src1 = src1_is_pc ? pc : rj_value.
- src2 = src2_is_imm ? imm : rkd_value.

ALU, alu_op one-hot:
- Bit 0 add; bit 1 sub; bit 2 slt (signed); bit 3 sltu.
- Bits 4–7: and, nor, or, xor.
- Bits 8–10: sll, srl, sra; the shift amount is src2[4:0].
- Bit 11 lui: result = src2.
- All-zero alu_op gives result 0.
- Arithmetic is 32-bit and wraps; carry is discarded.

Data SRAM:
- addr = alu_result.
- en = es_valid & (load_op | mem_we).
- we is 4'b0000 unless es_valid & mem_we. Otherwise, by st_type:
  - 00 (word): 4'b1111, wdata = rkd.
  - 01 (byte): 4'b0001 << addr[1:0], wdata = {4{rkd[7:0]}}.
  - 10 (half): addr[1] ? 4'b1100 : 4'b0011, wdata = {2{rkd[15:0]}}; addr[0] is ignored.
  - 11: 4'b0000.
- Misalignment raises no exception.

Decode feedback:
- es_to_ds_dest = (es_valid & gr_we & !inst_no_dest) ? dest : 5'd0.
- es_to_ds_load_op = es_valid & load_op.
- es_to_ds_result = alu_result. It is valid for non-loads only; decode stalls on loads.

## Timing

- Latency: one cycle. The instruction is captured at the edge and its result and SRAM request are combinational in the following cycle.
- The load's read data returns to the memory stage the next cycle (synchronous SRAM).
- When ms_allowin = 0, the stage holds and its outputs stay stable. The SRAM request repeats while held; re-writing the same store data and re-reading are idempotent and therefore allowed.
- When decode is not valid but es_allowin is high, es_valid clears to 0 (bubble).
- Reset, including reset mid-operation:
  - es_valid = 0 and bus_r = 0, so debug_ex_pc = 0.
  - Outputs: es_to_ms_valid = 0, es_to_ds_dest = 0, es_to_ds_load_op = 0, data_sram_en = 0, data_sram_we = 0, es_allowin = 1.
  - The in-flight instruction is discarded.
- Simultaneous reset and ds_to_es_valid: reset wins.

## Structure

- Bus widths, the alu_op bit indices, and the st_type/ld_type encodings live in mycpu_head.v.
- One sub-module, alu (alu_op, src1, src2 → result), purely combinational.
- The stage register, handshake logic and store formatting stay in exe_stage.

## Test plan

- **add.w.** Load r_j = 5 and r_k = 7 with alu_op = bit 0 and dest = 3. Next cycle: es_to_ms_bus alu_result = 12 and es_to_ds_dest = 3.
- **st.b.** rj = 0x1000, imm = 2, rkd = 0xAB, st_type = 01, mem_we = 1. Expect addr 0x1002, we 4'b0100, wdata 0xABABABAB, en = 1.
- **Shift and slt.**
  - sra with src1 = 0x80000000 and src2 = 0x24 → 0xF8000000.
  - slt with -1 vs 1 → 1.
  - sltu with the same operands → 0.
- **Backpressure.** Hold ms_allowin = 0 for 3 cycles with a valid instruction. Expect es_allowin = 0, the bus stable, and a new ds_to_es_bus ignored. After release, the instruction passes exactly once.
- **Load feedback.** ld.w with dest 5. Expect es_to_ds_load_op = 1, es_to_ds_dest = 5, en = 1, we = 0. A branch (inst_no_dest = 1) gives dest 0.
- **Reset mid-operation.** Assert reset while a store is valid. The next cycle shows es_valid = 0, we = 0, en = 0, debug_ex_pc = 0.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, ALU op bit indices,
// store/load type encodings and the packed layouts of the stage buses.
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD = 157;
  localparam int ES_TO_MS_BUS_WD = 74;

  // One-hot ALU operation bit indices.
  localparam int ALU_OP_W = 12;
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  typedef enum logic [1:0] {
    ST_WORD = 2'b00,
    ST_BYTE = 2'b01,
    ST_HALF = 2'b10,
    ST_NONE = 2'b11
  } st_type_e;

  // Load sub-type is only carried through to the memory stage here.
  typedef logic [2:0] ld_type_t;

  // Decode -> execute bus, MSB first.
  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                load_op;
    ld_type_t            ld_type;
    logic                src1_is_pc;
    logic                src2_is_imm;
    logic                gr_we;
    st_type_e            st_type;
    logic                mem_we;
    logic [4:0]          dest;
    logic [31:0]         imm;
    logic [31:0]         rj_value;
    logic [31:0]         rkd_value;
    logic [31:0]         pc;
    logic                res_from_mem;
    logic                inst_no_dest;
  } ds_to_es_bus_t;

  // Execute -> memory bus, MSB first.
  typedef struct packed {
    logic        res_from_mem;
    ld_type_t    ld_type;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_bus_t;

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational 32-bit ALU driven by a one-hot operation vector.
// An all-zero operation vector yields zero; arithmetic wraps.
module alu
  import exe_stage_pkg::*;
(
  input  logic [ALU_OP_W-1:0] i_alu_op,
  input  logic [31:0]         i_src1,
  input  logic [31:0]         i_src2,
  output logic [31:0]         o_result
);

  logic [31:0] w_add;
  logic [31:0] w_sub;
  logic [31:0] w_slt;
  logic [31:0] w_sltu;
  logic [31:0] w_sll;
  logic [31:0] w_srl;
  logic [31:0] w_sra;

  assign w_add  = i_src1 + i_src2;
  assign w_sub  = i_src1 - i_src2;
  assign w_slt  = {31'd0, ($signed(i_src1) < $signed(i_src2))};
  assign w_sltu = {31'd0, (i_src1 < i_src2)};
  assign w_sll  = i_src1 << i_src2[4:0];
  assign w_srl  = i_src1 >> i_src2[4:0];
  assign w_sra  = $signed(i_src1) >>> i_src2[4:0];

  // AND-OR select of every candidate result by its one-hot op bit.
  always_comb begin
    o_result = 32'd0;
    o_result = ({32{i_alu_op[ALU_ADD ]}} & w_add)
             | ({32{i_alu_op[ALU_SUB ]}} & w_sub)
             | ({32{i_alu_op[ALU_SLT ]}} & w_slt)
             | ({32{i_alu_op[ALU_SLTU]}} & w_sltu)
             | ({32{i_alu_op[ALU_AND ]}} & (i_src1 & i_src2))
             | ({32{i_alu_op[ALU_NOR ]}} & ~(i_src1 | i_src2))
             | ({32{i_alu_op[ALU_OR  ]}} & (i_src1 | i_src2))
             | ({32{i_alu_op[ALU_XOR ]}} & (i_src1 ^ i_src2))
             | ({32{i_alu_op[ALU_SLL ]}} & w_sll)
             | ({32{i_alu_op[ALU_SRL ]}} & w_srl)
             | ({32{i_alu_op[ALU_SRA ]}} & w_sra)
             | ({32{i_alu_op[ALU_LUI ]}} & i_src2);
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: latches the decode bus, runs the ALU, issues the data SRAM
// request for loads/stores and feeds destination/result back to decode.
//
// Handshake: an instruction moves from stage A to stage B on a clock edge
// exactly when A's valid and B's allowin are both high at that edge. While
// ms_allowin is low the stage holds its instruction and all outputs stay
// stable; the SRAM request repeats, which is harmless (idempotent).
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [4:0]                 es_to_ds_dest,
  output logic                       es_to_ds_load_op,
  output logic [31:0]                es_to_ds_result,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata,
  output logic [31:0]                debug_ex_pc
);

  logic          r_es_valid;
  ds_to_es_bus_t r_bus;

  logic          w_es_ready_go;
  logic [31:0]   w_src1;
  logic [31:0]   w_src2;
  logic [31:0]   w_alu_result;
  logic [3:0]    w_sram_we;
  logic [31:0]   w_sram_wdata;
  es_to_ms_bus_t w_ms_bus;

  // Execute always finishes in one cycle.
  assign w_es_ready_go  = 1'b1;
  assign es_allowin     = !r_es_valid || (w_es_ready_go && ms_allowin);
  assign es_to_ms_valid = r_es_valid && w_es_ready_go;

  // Stage valid: refilled from decode whenever the stage can accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_es_valid <= 1'b0;
    end else if (es_allowin) begin
      r_es_valid <= ds_to_es_valid;
    end
  end

  // Stage payload: captured only when a real instruction is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bus <= '0;
    end else if (ds_to_es_valid && es_allowin) begin
      r_bus <= ds_to_es_bus;
    end
  end

  assign w_src1 = r_bus.src1_is_pc  ? r_bus.pc  : r_bus.rj_value;
  assign w_src2 = r_bus.src2_is_imm ? r_bus.imm : r_bus.rkd_value;

  alu u_alu (
    .i_alu_op (r_bus.alu_op),
    .i_src1   (w_src1),
    .i_src2   (w_src2),
    .o_result (w_alu_result)
  );

  // Store formatting: byte-lane strobes from the low address bits and
  // replicated write data; misaligned halfwords just ignore addr[0].
  always_comb begin
    w_sram_we    = 4'b0000;
    w_sram_wdata = r_bus.rkd_value;
    case (r_bus.st_type)
      ST_BYTE: w_sram_wdata = {4{r_bus.rkd_value[7:0]}};
      ST_HALF: w_sram_wdata = {2{r_bus.rkd_value[15:0]}};
      default: w_sram_wdata = r_bus.rkd_value;
    endcase
    if (r_es_valid && r_bus.mem_we) begin
      case (r_bus.st_type)
        ST_WORD: w_sram_we = 4'b1111;
        ST_BYTE: w_sram_we = 4'b0001 << w_alu_result[1:0];
        ST_HALF: w_sram_we = w_alu_result[1] ? 4'b1100 : 4'b0011;
        default: w_sram_we = 4'b0000;
      endcase
    end
  end

  assign data_sram_en    = r_es_valid && (r_bus.load_op || r_bus.mem_we);
  assign data_sram_we    = w_sram_we;
  assign data_sram_addr  = w_alu_result;
  assign data_sram_wdata = w_sram_wdata;

  assign w_ms_bus.res_from_mem = r_bus.res_from_mem;
  assign w_ms_bus.ld_type      = r_bus.ld_type;
  assign w_ms_bus.gr_we        = r_bus.gr_we;
  assign w_ms_bus.dest         = r_bus.dest;
  assign w_ms_bus.alu_result   = w_alu_result;
  assign w_ms_bus.pc           = r_bus.pc;
  assign es_to_ms_bus          = w_ms_bus;

  // Decode feedback; the result is only meaningful for non-loads.
  assign es_to_ds_dest    = (r_es_valid && r_bus.gr_we && !r_bus.inst_no_dest) ? r_bus.dest : 5'd0;
  assign es_to_ds_load_op = r_es_valid && r_bus.load_op;
  assign es_to_ds_result  = w_alu_result;

  assign debug_ex_pc = r_bus.pc;

endmodule
